// File: rtl/ptw_req_arbiter_if.sv
// ptw_req_arbiter_if: TLB-miss, PTW-request and control signals around the PTW request arbiter.
// slave = arbiter side, master = surrounding MMU (ITLB, DTLB, PTW, sfence source).
interface ptw_req_arbiter_if #(
    parameter int unsigned VLEN       = 39,
    parameter int unsigned ASID_WIDTH = 16
);
    logic                  flush_i;
    logic [ASID_WIDTH-1:0] asid_i;

    logic                  itlb_req_i;
    logic [VLEN-1:0]       itlb_vaddr_i;
    logic                  itlb_gnt_o;
    logic                  itlb_done_o;

    logic                  dtlb_req_i;
    logic [VLEN-1:0]       dtlb_vaddr_i;
    logic                  dtlb_is_store_i;
    logic                  dtlb_gnt_o;
    logic                  dtlb_done_o;

    logic                  ptw_req_o;
    logic [VLEN-1:0]       ptw_vaddr_o;
    logic [ASID_WIDTH-1:0] ptw_asid_o;
    logic                  ptw_is_store_o;
    logic                  ptw_is_instr_o;
    logic                  ptw_ack_i;
    logic                  ptw_done_i;

    logic                  busy_o;

    modport slave (
        input  flush_i, asid_i,
        input  itlb_req_i, itlb_vaddr_i,
        input  dtlb_req_i, dtlb_vaddr_i, dtlb_is_store_i,
        input  ptw_ack_i, ptw_done_i,
        output itlb_gnt_o, itlb_done_o, dtlb_gnt_o, dtlb_done_o,
        output ptw_req_o, ptw_vaddr_o, ptw_asid_o, ptw_is_store_o, ptw_is_instr_o,
        output busy_o
    );

    modport master (
        output flush_i, asid_i,
        output itlb_req_i, itlb_vaddr_i,
        output dtlb_req_i, dtlb_vaddr_i, dtlb_is_store_i,
        output ptw_ack_i, ptw_done_i,
        input  itlb_gnt_o, itlb_done_o, dtlb_gnt_o, dtlb_done_o,
        input  ptw_req_o, ptw_vaddr_o, ptw_asid_o, ptw_is_store_o, ptw_is_instr_o,
        input  busy_o
    );
endinterface

// File: rtl/ptw_req_arbiter.sv
// ptw_req_arbiter: shares the single sv39 page-table walker between ITLB and DTLB misses.
// One walk outstanding at a time; sfence.vma (flush_i) drops an unacknowledged request or
// drains an accepted walk without reporting its completion.
// Build option: define CVA6_PTW_ARB_RR_EN for round-robin tie breaking; otherwise DTLB wins ties.
module ptw_req_arbiter #(
    parameter int unsigned VLEN       = 39,
    parameter int unsigned ASID_WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    ptw_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WALK  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic [VLEN-1:0]       vaddr;
        logic [ASID_WIDTH-1:0] asid;
        logic                  is_store;
        logic                  is_instr;
    } req_t;

    state_e state_q;
    state_e state_d;
    req_t   req_q;

    logic any_req;
    logic grant;
    logic pick_dtlb;
    logic itlb_gnt;
    logic dtlb_gnt;
    logic itlb_done;
    logic dtlb_done;
    logic ptw_req;
    logic busy;

    assign any_req = bus.itlb_req_i | bus.dtlb_req_i;
    assign grant   = (state_q == S_IDLE) & ~bus.flush_i & any_req;

`ifdef CVA6_PTW_ARB_RR_EN
    logic prio_dtlb_q;

    // Tie winner follows the pointer; a lone requester always wins.
    always_comb begin
        pick_dtlb = bus.dtlb_req_i & (~bus.itlb_req_i | prio_dtlb_q);
    end

    // Pointer moves to the requester that did not win the last grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_dtlb_q <= 1'b1;
        end else if (grant) begin
            prio_dtlb_q <= ~pick_dtlb;
        end
    end
`else
    // Fixed priority: DTLB wins whenever it requests.
    always_comb begin
        pick_dtlb = bus.dtlb_req_i;
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack/done outside their expected states are ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.ptw_ack_i) begin
                    state_d = bus.flush_i ? S_DRAIN : S_WALK;
                end else if (bus.flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WALK: begin
                if (bus.ptw_done_i) begin
                    state_d = S_IDLE;
                end else if (bus.flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.ptw_done_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: grants in IDLE, completion routed to the walk owner unless flushed.
    always_comb begin
        itlb_gnt  = 1'b0;
        dtlb_gnt  = 1'b0;
        itlb_done = 1'b0;
        dtlb_done = 1'b0;
        ptw_req   = 1'b0;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                dtlb_gnt = grant & pick_dtlb;
                itlb_gnt = grant & ~pick_dtlb;
            end
            S_REQ: begin
                ptw_req = 1'b1;
            end
            S_WALK: begin
                itlb_done = bus.ptw_done_i & ~bus.flush_i & req_q.is_instr;
                dtlb_done = bus.ptw_done_i & ~bus.flush_i & ~req_q.is_instr;
            end
            default: ;
        endcase
    end

    // Request register captures the winner's payload on grant and holds it for the walk.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= '0;
        end else if (grant) begin
            req_q.vaddr    <= pick_dtlb ? bus.dtlb_vaddr_i : bus.itlb_vaddr_i;
            req_q.asid     <= bus.asid_i;
            req_q.is_store <= pick_dtlb & bus.dtlb_is_store_i;
            req_q.is_instr <= ~pick_dtlb;
        end
    end

    assign bus.itlb_gnt_o     = itlb_gnt;
    assign bus.dtlb_gnt_o     = dtlb_gnt;
    assign bus.itlb_done_o    = itlb_done;
    assign bus.dtlb_done_o    = dtlb_done;
    assign bus.ptw_req_o      = ptw_req;
    assign bus.busy_o         = busy;
    assign bus.ptw_vaddr_o    = req_q.vaddr;
    assign bus.ptw_asid_o     = req_q.asid;
    assign bus.ptw_is_store_o = req_q.is_store;
    assign bus.ptw_is_instr_o = req_q.is_instr;

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// tb_ptw_req_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ptw_req_arbiter;
    localparam int unsigned VLEN       = 39;
    localparam int unsigned ASID_WIDTH = 16;
`ifdef CVA6_PTW_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ptw_req_arbiter_if #(.VLEN(VLEN), .ASID_WIDTH(ASID_WIDTH)) bus ();

    ptw_req_arbiter #(.VLEN(VLEN), .ASID_WIDTH(ASID_WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic quiet_inputs();
        bus.flush_i         = 1'b0;
        bus.asid_i          = '0;
        bus.itlb_req_i      = 1'b0;
        bus.itlb_vaddr_i    = '0;
        bus.dtlb_req_i      = 1'b0;
        bus.dtlb_vaddr_i    = '0;
        bus.dtlb_is_store_i = 1'b0;
        bus.ptw_ack_i       = 1'b0;
        bus.ptw_done_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet_inputs();
        #2;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_cmp++; if (bus.ptw_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_ptw_req: got %b want 0", bus.ptw_req_o); end
        n_cmp++; if (bus.ptw_vaddr_o !== 39'h0) begin n_fail++; $display("FAIL reset_vaddr: got %h want 0", bus.ptw_vaddr_o); end
        n_cmp++; if ({bus.ptw_is_store_o, bus.ptw_is_instr_o, bus.ptw_asid_o} !== 18'h0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", {bus.ptw_is_store_o, bus.ptw_is_instr_o, bus.ptw_asid_o}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_itlb();
        @(negedge clk);
        bus.itlb_req_i   = 1'b1;
        bus.itlb_vaddr_i = 39'h40_0000_1000;
        bus.asid_i       = 16'h00a5;
        #1;
        n_cmp++; if (bus.itlb_gnt_o !== 1'b1) begin n_fail++; $display("FAIL single_itlb_gnt: got %b want 1", bus.itlb_gnt_o); end
        n_cmp++; if (bus.dtlb_gnt_o !== 1'b0) begin n_fail++; $display("FAIL single_dtlb_gnt: got %b want 0", bus.dtlb_gnt_o); end
        n_cmp++; if (bus.ptw_req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_early: got %b want 0", bus.ptw_req_o); end
        @(negedge clk);
        bus.itlb_req_i   = 1'b0;
        bus.itlb_vaddr_i = '0;
        bus.asid_i       = 16'hffff;
        #1;
        n_cmp++; if (bus.ptw_req_o !== 1'b1) begin n_fail++; $display("FAIL single_ptw_req: got %b want 1", bus.ptw_req_o); end
        n_cmp++; if (bus.ptw_vaddr_o !== 39'h40_0000_1000) begin n_fail++; $display("FAIL single_vaddr: got %h want 4000001000", bus.ptw_vaddr_o); end
        n_cmp++; if (bus.ptw_is_instr_o !== 1'b1) begin n_fail++; $display("FAIL single_is_instr: got %b want 1", bus.ptw_is_instr_o); end
        n_cmp++; if (bus.ptw_asid_o !== 16'h00a5) begin n_fail++; $display("FAIL single_asid: got %h want 00a5", bus.ptw_asid_o); end
        n_cmp++; if (bus.itlb_gnt_o !== 1'b0) begin n_fail++; $display("FAIL single_gnt_busy: got %b want 0", bus.itlb_gnt_o); end
        @(negedge clk);
        @(negedge clk);
        bus.ptw_ack_i = 1'b1;
        #1;
        n_cmp++; if (bus.ptw_req_o !== 1'b1) begin n_fail++; $display("FAIL single_req_held: got %b want 1", bus.ptw_req_o); end
        @(negedge clk);
        bus.ptw_ack_i = 1'b0;
        #1;
        n_cmp++; if ({bus.ptw_req_o, bus.busy_o} !== 2'b01) begin n_fail++; $display("FAIL single_walk: req,busy got %b want 01", {bus.ptw_req_o, bus.busy_o}); end
        repeat (4) begin
            @(negedge clk);
            #1;
            n_cmp++; if (bus.itlb_done_o !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %b want 0", bus.itlb_done_o); end
        end
        @(negedge clk);
        bus.ptw_done_i = 1'b1;
        #1;
        n_cmp++; if (bus.itlb_done_o !== 1'b1) begin n_fail++; $display("FAIL single_itlb_done: got %b want 1", bus.itlb_done_o); end
        n_cmp++; if (bus.dtlb_done_o !== 1'b0) begin n_fail++; $display("FAIL single_dtlb_done: got %b want 0", bus.dtlb_done_o); end
        @(negedge clk);
        bus.ptw_done_i = 1'b0;
        #1;
        n_cmp++; if ({bus.itlb_done_o, bus.busy_o} !== 2'b00) begin n_fail++; $display("FAIL single_after_done: done,busy got %b want 00", {bus.itlb_done_o, bus.busy_o}); end
    endtask

    task automatic test_simultaneous();
        bit exp_d;
        for (int k = 0; k < 4; k++) begin
            exp_d = RR ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            bus.itlb_req_i   = 1'b1;
            bus.dtlb_req_i   = 1'b1;
            bus.itlb_vaddr_i = 39'(64'h100 + 64'(k));
            bus.dtlb_vaddr_i = 39'(64'h200 + 64'(k));
            #1;
            n_cmp++; if ({bus.dtlb_gnt_o, bus.itlb_gnt_o} !== {exp_d, ~exp_d}) begin n_fail++; $display("FAIL tie_grant_%0d: dtlb,itlb got %b want %b", k, {bus.dtlb_gnt_o, bus.itlb_gnt_o}, {exp_d, ~exp_d}); end
            @(negedge clk);
            bus.itlb_req_i = 1'b0;
            bus.dtlb_req_i = 1'b0;
            bus.ptw_ack_i  = 1'b1;
            #1;
            n_cmp++; if (bus.ptw_is_instr_o !== ~exp_d) begin n_fail++; $display("FAIL tie_owner_%0d: got %b want %b", k, bus.ptw_is_instr_o, ~exp_d); end
            n_cmp++; if (bus.ptw_vaddr_o !== (exp_d ? 39'(64'h200 + 64'(k)) : 39'(64'h100 + 64'(k)))) begin n_fail++; $display("FAIL tie_vaddr_%0d: got %h", k, bus.ptw_vaddr_o); end
            @(negedge clk);
            bus.ptw_ack_i  = 1'b0;
            bus.ptw_done_i = 1'b1;
            #1;
            n_cmp++; if ({bus.dtlb_done_o, bus.itlb_done_o} !== {exp_d, ~exp_d}) begin n_fail++; $display("FAIL tie_done_%0d: dtlb,itlb got %b want %b", k, {bus.dtlb_done_o, bus.itlb_done_o}, {exp_d, ~exp_d}); end
            @(negedge clk);
            bus.ptw_done_i = 1'b0;
        end
    endtask

    task automatic test_store_flag();
        @(negedge clk);
        bus.dtlb_req_i      = 1'b1;
        bus.dtlb_is_store_i = 1'b1;
        bus.dtlb_vaddr_i    = 39'h7F_FFFF_F000;
        #1;
        n_cmp++; if (bus.dtlb_gnt_o !== 1'b1) begin n_fail++; $display("FAIL store_gnt: got %b want 1", bus.dtlb_gnt_o); end
        @(negedge clk);
        bus.dtlb_req_i      = 1'b0;
        bus.dtlb_is_store_i = 1'b0;
        bus.dtlb_vaddr_i    = '0;
        bus.ptw_ack_i       = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if ({bus.ptw_is_store_o, bus.ptw_is_instr_o} !== 2'b10) begin n_fail++; $display("FAIL store_flags_%0d: store,instr got %b want 10", c, {bus.ptw_is_store_o, bus.ptw_is_instr_o}); end
            n_cmp++; if (bus.ptw_vaddr_o !== 39'h7F_FFFF_F000) begin n_fail++; $display("FAIL store_vaddr_%0d: got %h want 7ffffff000", c, bus.ptw_vaddr_o); end
            @(negedge clk);
            bus.ptw_ack_i = 1'b0;
        end
        bus.ptw_done_i = 1'b1;
        #1;
        n_cmp++; if ({bus.dtlb_done_o, bus.itlb_done_o, bus.ptw_is_store_o} !== 3'b101) begin n_fail++; $display("FAIL store_done: dtlb,itlb,store got %b want 101", {bus.dtlb_done_o, bus.itlb_done_o, bus.ptw_is_store_o}); end
        @(negedge clk);
        bus.ptw_done_i = 1'b0;
    endtask

    task automatic test_flush_req();
        @(negedge clk);
        bus.itlb_req_i = 1'b1;
        bus.itlb_vaddr_i = 39'h12_3456_7000;
        @(negedge clk);
        bus.itlb_req_i = 1'b0;
        bus.flush_i    = 1'b1;
        #1;
        n_cmp++; if (bus.ptw_req_o !== 1'b1) begin n_fail++; $display("FAIL flreq_in_req: got %b want 1", bus.ptw_req_o); end
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.ptw_done_i = 1'b1;
        #1;
        n_cmp++; if ({bus.ptw_req_o, bus.busy_o, bus.itlb_done_o, bus.dtlb_done_o} !== 4'b0000) begin n_fail++; $display("FAIL flreq_dropped: req,busy,idone,ddone got %b want 0000", {bus.ptw_req_o, bus.busy_o, bus.itlb_done_o, bus.dtlb_done_o}); end
        @(negedge clk);
        bus.ptw_done_i = 1'b0;
        bus.dtlb_req_i = 1'b1;
        @(negedge clk);
        bus.dtlb_req_i = 1'b0;
        bus.flush_i    = 1'b1;
        bus.ptw_ack_i  = 1'b1;
        @(negedge clk);
        bus.flush_i   = 1'b0;
        bus.ptw_ack_i = 1'b0;
        #1;
        n_cmp++; if ({bus.ptw_req_o, bus.busy_o, bus.ptw_is_instr_o} !== 3'b010) begin n_fail++; $display("FAIL flreq_drain: req,busy,instr got %b want 010", {bus.ptw_req_o, bus.busy_o, bus.ptw_is_instr_o}); end
        @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL flreq_drain_hold: got %b want 1", bus.busy_o); end
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.ptw_done_i = 1'b1;
        #1;
        n_cmp++; if ({bus.itlb_done_o, bus.dtlb_done_o, bus.busy_o} !== 3'b001) begin n_fail++; $display("FAIL flreq_drain_done: idone,ddone,busy got %b want 001", {bus.itlb_done_o, bus.dtlb_done_o, bus.busy_o}); end
        @(negedge clk);
        bus.ptw_done_i = 1'b0;
        #1;
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flreq_drain_idle: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_flush_walk();
        @(negedge clk);
        bus.itlb_req_i = 1'b1;
        @(negedge clk);
        bus.itlb_req_i = 1'b0;
        bus.ptw_ack_i  = 1'b1;
        @(negedge clk);
        bus.ptw_ack_i = 1'b0;
        bus.flush_i   = 1'b1;
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.itlb_req_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.ptw_done_i = 1'b1;
        #1;
        n_cmp++; if ({bus.itlb_done_o, bus.dtlb_done_o} !== 2'b00) begin n_fail++; $display("FAIL flwalk_no_done: idone,ddone got %b want 00", {bus.itlb_done_o, bus.dtlb_done_o}); end
        n_cmp++; if ({bus.busy_o, bus.itlb_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL flwalk_busy: busy,gnt got %b want 10", {bus.busy_o, bus.itlb_gnt_o}); end
        @(negedge clk);
        bus.ptw_done_i = 1'b0;
        #1;
        n_cmp++; if ({bus.busy_o, bus.itlb_gnt_o} !== 2'b01) begin n_fail++; $display("FAIL flwalk_regrant: busy,gnt got %b want 01", {bus.busy_o, bus.itlb_gnt_o}); end
        @(negedge clk);
        bus.itlb_req_i = 1'b0;
        bus.flush_i    = 1'b1;
        #1;
        n_cmp++; if (bus.ptw_req_o !== 1'b1) begin n_fail++; $display("FAIL flwalk_req: got %b want 1", bus.ptw_req_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.dtlb_req_i   = 1'b1;
        bus.dtlb_vaddr_i = 39'h55_5555_5000;
        bus.asid_i       = 16'h0bcd;
        @(negedge clk);
        quiet_inputs();
        bus.ptw_ack_i = 1'b1;
        @(negedge clk);
        bus.ptw_ack_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.busy_o, bus.ptw_req_o, bus.ptw_is_instr_o, bus.ptw_is_store_o} !== 4'b0000) begin n_fail++; $display("FAIL areset_ctrl: got %b want 0000", {bus.busy_o, bus.ptw_req_o, bus.ptw_is_instr_o, bus.ptw_is_store_o}); end
        n_cmp++; if ({bus.ptw_vaddr_o, bus.ptw_asid_o} !== 55'h0) begin n_fail++; $display("FAIL areset_payload: got %h want 0", {bus.ptw_vaddr_o, bus.ptw_asid_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.itlb_req_i = 1'b1;
        bus.dtlb_req_i = 1'b1;
        #1;
        n_cmp++; if ({bus.dtlb_gnt_o, bus.itlb_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL areset_prio: dtlb,itlb got %b want 10", {bus.dtlb_gnt_o, bus.itlb_gnt_o}); end
        @(negedge clk);
        quiet_inputs();
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
    endtask

    task automatic test_random();
        bit ip, dp, ds, fl, ak, dn, win_d, e_ig, e_dg, e_dn;
        bit m_active, m_acked, m_aborted, m_instr, m_store, m_last_dtlb;
        logic [VLEN-1:0]       ia, da, m_vaddr;
        logic [ASID_WIDTH-1:0] asid, m_asid;
        @(negedge clk);
        quiet_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        {ip, dp, ds} = '0;
        {m_active, m_acked, m_aborted, m_instr, m_store, m_last_dtlb} = '0;
        ia = '0; da = '0; m_vaddr = '0; m_asid = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!ip && $urandom_range(0, 3) == 0) begin
                ip = 1'b1; ia = VLEN'({$urandom, $urandom});
            end else if (ip && $urandom_range(0, 31) == 0) begin
                ip = 1'b0;
            end
            if (!dp && $urandom_range(0, 3) == 0) begin
                dp = 1'b1; da = VLEN'({$urandom, $urandom}); ds = 1'($urandom);
            end else if (dp && $urandom_range(0, 31) == 0) begin
                dp = 1'b0;
            end
            fl   = ($urandom_range(0, 7) == 0);
            ak   = 1'($urandom);
            dn   = ($urandom_range(0, 2) == 0);
            asid = ASID_WIDTH'($urandom);
            bus.itlb_req_i = ip; bus.itlb_vaddr_i = ia;
            bus.dtlb_req_i = dp; bus.dtlb_vaddr_i = da; bus.dtlb_is_store_i = ds;
            bus.flush_i = fl; bus.ptw_ack_i = ak; bus.ptw_done_i = dn; bus.asid_i = asid;
            #1;
            win_d = dp && (!ip || !RR || !m_last_dtlb);
            e_dg  = !m_active && !fl && win_d;
            e_ig  = !m_active && !fl && ip && !win_d;
            e_dn  = m_active && m_acked && dn && !m_aborted && !fl;
            n_cmp++; if ({bus.itlb_gnt_o, bus.dtlb_gnt_o} !== {e_ig, e_dg}) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: itlb,dtlb got %b want %b", cyc, {bus.itlb_gnt_o, bus.dtlb_gnt_o}, {e_ig, e_dg}); end
            n_cmp++; if ({bus.itlb_done_o, bus.dtlb_done_o} !== {e_dn && m_instr, e_dn && !m_instr}) begin n_fail++; $display("FAIL rnd_done cyc %0d: itlb,dtlb got %b want %b", cyc, {bus.itlb_done_o, bus.dtlb_done_o}, {e_dn && m_instr, e_dn && !m_instr}); end
            n_cmp++; if ({bus.ptw_req_o, bus.busy_o} !== {m_active && !m_acked, m_active}) begin n_fail++; $display("FAIL rnd_req_busy cyc %0d: got %b want %b", cyc, {bus.ptw_req_o, bus.busy_o}, {m_active && !m_acked, m_active}); end
            if (m_active) begin
                n_cmp++; if ({bus.ptw_vaddr_o, bus.ptw_asid_o, bus.ptw_is_store_o, bus.ptw_is_instr_o} !== {m_vaddr, m_asid, m_store, m_instr}) begin n_fail++; $display("FAIL rnd_payload cyc %0d: got %h want %h", cyc, {bus.ptw_vaddr_o, bus.ptw_asid_o, bus.ptw_is_store_o, bus.ptw_is_instr_o}, {m_vaddr, m_asid, m_store, m_instr}); end
            end
            if (!m_active) begin
                if (e_ig || e_dg) begin
                    m_active = 1'b1; m_acked = 1'b0; m_aborted = 1'b0;
                    m_instr = e_ig; m_vaddr = e_ig ? ia : da; m_asid = asid;
                    m_store = e_dg && ds; m_last_dtlb = e_dg;
                end
            end else if (!m_acked) begin
                if (ak) begin
                    m_acked = 1'b1; m_aborted = fl;
                end else if (fl) begin
                    m_active = 1'b0;
                end
            end else begin
                if (dn) m_active = 1'b0;
                else if (fl) m_aborted = 1'b1;
            end
            if (e_ig) ip = 1'b0;
            if (e_dg) dp = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_itlb();
        test_simultaneous();
        test_store_flag();
        test_flush_req();
        test_flush_walk();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ptw_req_arbiter.md
# ptw_req_arbiter

Shares the single page-table walker between instruction-TLB and data-TLB misses in the sv39 MMU. It accepts one miss at a time, presents it to the PTW with a stable request/acknowledge handshake, and tracks the walk to completion. It then routes the completion pulse back to the TLB that owns the walk. An `sfence.vma` flush aborts or drains any walk in flight. The block sits between the ITLB/DTLB miss outputs and the PTW request port inside the MMU.

## Interface
Parameters:
- `VLEN`, 39: virtual address width (sv39).
- `ASID_WIDTH`, 16: address-space ID width forwarded with each request.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `flush_i`  in  1: sfence.vma; aborts or drains the current walk.
- `asid_i`  in  ASID_WIDTH: current ASID, latched with the winning request.
- `itlb_req_i`  in  1: ITLB miss request; level, held until `itlb_gnt_o`.
- `itlb_vaddr_i`  in  VLEN: ITLB miss address.
- `itlb_gnt_o`  out  1: one-cycle pulse; the ITLB request is captured.
- `itlb_done_o`  out  1: one-cycle pulse; the ITLB-owned walk has completed.
- `dtlb_req_i`  in  1: DTLB miss request; level, held until `dtlb_gnt_o`.
- `dtlb_vaddr_i`  in  VLEN: DTLB miss address.
- `dtlb_is_store_i`  in  1: the DTLB miss comes from a store or AMO.
- `dtlb_gnt_o`  out  1: one-cycle pulse; the DTLB request is captured.
- `dtlb_done_o`  out  1: one-cycle pulse; the DTLB-owned walk has completed.
- `ptw_req_o`  out  1: walk request to the PTW.
- `ptw_vaddr_o`  out  VLEN: latched request address.
- `ptw_asid_o`  out  ASID_WIDTH: latched ASID.
- `ptw_is_store_o`  out  1: latched store flag; always 0 for ITLB requests.
- `ptw_is_instr_o`  out  1: 1 when the ITLB owns the walk.
- `ptw_ack_i`  in  1: the PTW accepts the request.
- `ptw_done_i`  in  1: the walk has finished, either with a TLB update or with a fault.
- `busy_o`  out  1: the state is not IDLE.

## Operation
The block is a four-state FSM.
- **IDLE**
  - With any request pending and `flush_i`=0, assert the winner's gnt combinationally.
  - Latch the winner's vaddr, ASID and is_store into the request register, record the owner, and go to REQ.
  - `flush_i`=1 blocks all grants that cycle.
- **REQ**
  - Hold `ptw_req_o`=1 with stable latched outputs.
  - `ptw_ack_i`=1 goes to WALK.
  - `flush_i`=1 without `ptw_ack_i` goes to IDLE and the request is dropped.
  - `flush_i`=1 together with `ptw_ack_i` goes to DRAIN.
- **WALK**
  - `ptw_done_i`=1 pulses the owner's done output and goes to IDLE.
  - `flush_i`=1 goes to DRAIN.
  - `flush_i` and `ptw_done_i` in the same cycle: no done pulse, go to IDLE.
- **DRAIN**
  - Wait for `ptw_done_i`, then go to IDLE with no done pulse.
  - Further flushes are ignored.

Other rules:
- At most one walk is outstanding. Gnt is never asserted outside IDLE.
- A requester whose req drops before it is granted is simply not served. There is no queueing inside the block.
- `ptw_is_store_o` and `ptw_is_instr_o` stay valid from REQ through DRAIN.

## Timing
- Reset state:
  - FSM in IDLE, all outputs 0.
  - Request register 0.
  - Priority pointer set to DTLB.
- Latencies:
  - Request to gnt: 0 cycles (combinational, in IDLE).
  - Gnt to `ptw_req_o`: 1 cycle.
  - `ptw_ack_i` to WALK: next edge.
  - `ptw_done_i` to done pulse: 0 cycles (combinational, in WALK).
  - Done to the next possible gnt: 1 cycle.
- The earliest back-to-back grant is the cycle after `ptw_done_i`.
- `ptw_ack_i` or `ptw_done_i` arriving outside the state that expects it is ignored.
- Reset asserted mid-walk returns the FSM to IDLE immediately with no pulses. The PTW is reset by the same `rst_ni`.

## Configuration
- `CVA6_PTW_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the requester named by the priority pointer wins.
  - After every grant, the pointer moves to the other requester.
- `CVA6_PTW_ARB_RR_EN` undefined: fixed priority, DTLB always wins ties.
  - The pointer register is not instantiated.

## Test plan
- **Single ITLB miss:** `itlb_req_i`=1 with vaddr 0x40_0000_1000 while IDLE.
  - Expect `itlb_gnt_o` the same cycle and `ptw_req_o` the next cycle with that vaddr and `ptw_is_instr_o`=1.
  - Apply ack 2 cycles later and done 5 cycles after that; expect `itlb_done_o` one-cycle pulse and `dtlb_done_o`=0.
- **Simultaneous requests with RR:** ITLB and DTLB both request in every IDLE slot.
  - Expect grants in the order DTLB, ITLB, DTLB, ITLB.
  - Without the macro, expect DTLB on every grant.
- **Store flag:** DTLB request with `dtlb_is_store_i`=1 and vaddr 0x7F_FFFF_F000.
  - Expect `ptw_is_store_o`=1 and `ptw_vaddr_o`=0x7F_FFFF_F000, held until done.
- **Flush in REQ:** flush arrives before ack; expect IDLE next cycle, `ptw_req_o`=0, no done pulse.
  - Repeat with flush and ack in the same cycle; expect DRAIN, then IDLE after done, with no pulse.
- **Flush in WALK:** flush, then 3 cycles later ptw_done; expect no done pulse and busy_o falling one cycle after done.
  - A pending ITLB request is granted the cycle after return to IDLE.
- **Async reset mid-walk:** deassert `rst_ni` in WALK.
  - Expect all outputs 0 asynchronously and the DTLB priority restored.
